// File: rtl/fifo_rd_packer_if.sv
// rtl/fifo_rd_packer_if.sv - FIFO read port and packed output stream of fifo_rd_packer.
// master: the packer side; slave: the FIFO/downstream side.
interface fifo_rd_packer_if #(
   parameter int WIDTH = 8,
   parameter int LANES = 4
);
   logic [WIDTH-1:0]       fifo_data;
   logic                   fifo_empty;
   logic                   fifo_rd_en;
   logic                   flush;
   logic [WIDTH*LANES-1:0] m_data;
   logic [LANES-1:0]       m_keep;
   logic                   m_valid;
   logic                   m_ready;
   logic [15:0]            byte_count;

   modport master (
      input  fifo_data, fifo_empty, flush, m_ready,
      output fifo_rd_en, m_data, m_keep, m_valid, byte_count
   );

   modport slave (
      output fifo_data, fifo_empty, flush, m_ready,
      input  fifo_rd_en, m_data, m_keep, m_valid, byte_count
   );
endinterface

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - packs LANES show-ahead FIFO entries into one valid/ready word.
// Optional idle-timeout auto-flush under macro PACK_TIMEOUT_EN.
module fifo_rd_packer #(
   parameter int WIDTH   = 8,
   parameter int LANES   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic             rd_clk,
   input  logic             reset,
   fifo_rd_packer_if.master bus
);
   localparam int CW = $clog2(LANES);
   localparam logic [CW-1:0] LAST = CW'(LANES - 1);

   generate
      if (LANES < 2 || TIMEOUT < 1) begin : g_param_check
         $error("fifo_rd_packer: LANES must be >= 2 and TIMEOUT >= 1");
      end
   endgenerate

   typedef enum logic [0:0] {ACCUM, FLUSH_WAIT} state_t;

   state_t                 state_q, state_d;
   logic [WIDTH*LANES-1:0] acc_q, acc_d;
   logic [WIDTH*LANES-1:0] m_data_q, m_data_d;
   logic [LANES-1:0]       m_keep_q, m_keep_d;
   logic                   m_valid_q, m_valid_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [15:0]            bc_q, bc_d;

   logic                   out_free;
   logic                   pop;
   logic                   fill;
   logic                   flush_req;
   logic                   timeout_hit;
   logic [WIDTH*LANES-1:0] word;
   logic [WIDTH*LANES-1:0] partial;
   logic [LANES-1:0]       partial_keep;

   assign out_free  = !m_valid_q || bus.m_ready;
   // Holding reset in the enable keeps the FIFO from losing an entry while we are held in reset.
   assign pop       = reset && (state_q == ACCUM) && !bus.fifo_empty &&
                      ((cnt_q < LAST) || out_free);
   assign fill      = pop && (cnt_q == LAST);
   assign flush_req = bus.flush || timeout_hit;

`ifdef PACK_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] idle_q, idle_d;

   assign timeout_hit = (state_q == ACCUM) && (cnt_q != '0) && (idle_q == TW'(TIMEOUT));

   always_comb begin
      idle_d = idle_q + TW'(1);
      if (state_q != ACCUM || pop || cnt_q == '0 || timeout_hit) begin
         idle_d = '0;
      end
   end

   always_ff @(posedge rd_clk or negedge reset) begin
      if (!reset) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_d;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      word         = acc_q;
      partial      = '0;
      partial_keep = '0;
      for (int i = 0; i < LANES; i++) begin
         if (CW'(i) == cnt_q) begin
            word[i*WIDTH +: WIDTH] = bus.fifo_data;
         end
         if (CW'(i) < cnt_q) begin
            partial[i*WIDTH +: WIDTH] = acc_q[i*WIDTH +: WIDTH];
            partial_keep[i]           = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      m_data_d  = m_data_q;
      m_keep_d  = m_keep_q;
      m_valid_d = m_valid_q;
      cnt_d     = cnt_q;
      bc_d      = bc_q;

      if (m_valid_q && bus.m_ready) begin
         m_valid_d = 1'b0;
      end

      case (state_q)
         ACCUM: begin
            if (pop) begin
               acc_d = word;
               bc_d  = bc_q + 16'd1;
               if (fill) begin
                  m_data_d  = word;
                  m_keep_d  = '1;
                  m_valid_d = 1'b1;
                  cnt_d     = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            // A flush racing the filling pop is absorbed by the full word.
            if (flush_req && !fill && (pop || cnt_q != '0)) begin
               state_d = FLUSH_WAIT;
            end
         end
         FLUSH_WAIT: begin
            if (out_free) begin
               m_data_d  = partial;
               m_keep_d  = partial_keep;
               m_valid_d = 1'b1;
               cnt_d     = '0;
               state_d   = ACCUM;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge rd_clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ACCUM;
         acc_q     <= '0;
         m_data_q  <= '0;
         m_keep_q  <= '0;
         m_valid_q <= 1'b0;
         cnt_q     <= '0;
         bc_q      <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         m_data_q  <= m_data_d;
         m_keep_q  <= m_keep_d;
         m_valid_q <= m_valid_d;
         cnt_q     <= cnt_d;
         bc_q      <= bc_d;
      end
   end

   assign bus.fifo_rd_en = pop;
   assign bus.m_data     = m_data_q;
   assign bus.m_keep     = m_keep_q;
   assign bus.m_valid    = m_valid_q;
   assign bus.byte_count = bc_q;
endmodule
